dm_lsu: RTL and testbench
=========================

Name: dm_lsu

Overview:
Load/store initiator that drives the SISC data memory port on behalf of the control path. It accepts one read or write request at a time and generates the read address, write address and write data. For writes it produces a clean dm_we pulse; the memory commits on the falling edge of that pulse. For reads it captures the combinational read data after a settle window and returns it with a one-cycle response strobe.

Parameters:
WE_PULSE, 2, cycles dm_we is held high per write (>=1).
RD_WAIT, 1, cycles read address is held before read data is sampled (>=1).
DM_TOP, 16'hFFFC, highest implemented word address; anything above it is rejected.

Ports:
clk  in  1  system clock, all state updates on posedge.
rst_f  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  16  word address.
req_wdata  in  32  store data.
resp_valid  out  1  one-cycle completion strobe.
resp_we  out  1  completion is for a store.
resp_err  out  1  address above DM_TOP; no memory access was made.
resp_rdata  out  32  load data; valid only with resp_valid && !resp_we && !resp_err.
dm_read_addr  out  16  to memory read_addr.
dm_write_addr  out  16  to memory write_addr.
dm_write_data  out  32  to memory write_data.
dm_we  out  1  to memory dm_we; falling edge commits the write.
dm_read_data  in  32  from memory read_data.

Behaviour:
- Reset values (async on rst_f low): state IDLE, req_ready 1, resp_valid 0, resp_we 0, resp_err 0, resp_rdata 0, dm_read_addr 0, dm_we 0.
- dm_write_addr and dm_write_data have no reset. They load only on acceptance of a store.
- Accept rule: a request is accepted on the posedge where req_valid && req_ready. req_ready is 1 only in IDLE. The block never buffers more than one request.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_DONE, ERR.
- Out-of-range request (req_addr > DM_TOP):
  - IDLE -> ERR.
  - In ERR: resp_valid=1, resp_err=1, resp_we=req_we as latched, dm_we stays 0, dm addresses unchanged.
  - ERR -> IDLE.
- Store:
  - IDLE -> WR_SETUP. dm_write_addr/dm_write_data are loaded at the accept edge. dm_we=0.
  - WR_SETUP lasts 1 cycle -> WR_PULSE.
  - WR_PULSE: dm_we=1 for exactly WE_PULSE cycles, counted by a down-counter loaded with WE_PULSE-1.
  - WR_PULSE -> WR_HOLD. dm_we falls at this edge, which commits the write.
  - WR_HOLD: address/data still held, resp_valid=1, resp_we=1. Then -> IDLE.
  - Store ack arrives WE_PULSE+2 cycles after the accept edge.
- Load:
  - IDLE -> RD_WAIT. dm_read_addr is loaded at the accept edge.
  - RD_WAIT lasts RD_WAIT cycles. On the edge leaving RD_WAIT, dm_read_data is registered into resp_rdata.
  - RD_DONE: resp_valid=1, resp_we=0. Then -> IDLE.
  - Load latency is RD_WAIT+1 cycles.
- dm_read_addr holds its last value between loads. dm_we is never high outside WR_PULSE.
- Back-to-back: a new request can be accepted the cycle after resp_valid, because IDLE is re-entered then. Store then load to the same address must return the stored word, since the commit precedes the load accept.
- Reset during WR_PULSE: dm_we drops immediately. The memory commits the in-flight word exactly once, using the held addr/data. No response is issued.
- Reset in any other state: no memory side effect and no response.
- resp_rdata holds its value until the next load completes.

Decomposition:
- Package dm_lsu_pkg holds:
  - state enum (7 states);
  - DM_ADDR_W=16, DM_DATA_W=32;
  - default DM_TOP;
  - counter width as $clog2 of max(WE_PULSE, RD_WAIT)+1.
- One natural sub-module: dm_we_pulse_gen. It contains the down-counter and dm_we register, takes a start input and gives a done output, and is reusable for the RD_WAIT count.
- FSM, address/data registers and response logic stay in dm_lsu.

Test Plan:
1. Store addr 16'h0010 data 32'hDEADBEEF (WE_PULSE=2) -> dm_we high for exactly 2 cycles; ack (resp_valid, resp_we=1) 4 cycles after accept; dm model holds DEADBEEF at 0x0010.
2. Preload 0x0020=32'h12345678, load 0x0020 (RD_WAIT=1) -> resp_valid 2 cycles after accept with resp_rdata=12345678; req_ready low throughout.
3. Store 0x0030=32'hA5A5A5A5, then load 0x0030 on the first ready cycle -> resp_rdata=A5A5A5A5; no X on dm_write_addr during the pulse.
4. Load 16'hFFFE and store 16'hFFFD -> each gives one resp_valid with resp_err=1; dm_we never rises; memory unchanged.
5. Store 0x0040=32'h0BADF00D, assert rst_f low in the 2nd WR_PULSE cycle -> dm_we 0 immediately, 0x0040=0BADF00D written once, no resp_valid; after release all outputs at reset values, req_ready=1.
6. Hold req_valid high with 8 alternating store/load requests -> exactly 8 resp_valid pulses, in order, with no overlap and correct data.

Source files
------------

// File: rtl/dm_lsu_pkg.sv
// Shared types and constants for the SISC data-memory load/store initiator.
package dm_lsu_pkg;
    localparam int          DM_ADDR_W  = 16;
    localparam int          DM_DATA_W  = 32;
    localparam logic [15:0] DM_TOP_DEF = 16'hFFFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_ERR
    } state_t;

    // Counter must hold max(WE_PULSE, RD_WAIT)-1; sized as $clog2(max+1).
    function automatic int cnt_width(input int we_pulse, input int rd_wait);
        int m;
        m = (we_pulse > rd_wait) ? we_pulse : rd_wait;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction
endpackage

// File: rtl/dm_we_pulse_gen.sv
// Down-counting window timer; optionally drives a registered write-enable for the window.
module dm_we_pulse_gen #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             i_start,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_we,
    output logic             o_done
);
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;

    // Window length is i_load+1 cycles; o_done flags the last one.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= i_load;
            r_we     <= i_we;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
                r_we     <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_we   = r_we;
    assign o_done = r_active && (r_cnt == '0);
endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator for the SISC data memory: one request at a time, clean
// dm_we pulse for stores (commit on its falling edge), timed sample for loads.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int          WE_PULSE = 2,
    parameter int          RD_WAIT  = 1,
    parameter logic [15:0] DM_TOP   = DM_TOP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_f,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DM_ADDR_W-1:0] req_addr,
    input  logic [DM_DATA_W-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_we,
    output logic                 resp_err,
    output logic [DM_DATA_W-1:0] resp_rdata,
    output logic [DM_ADDR_W-1:0] dm_read_addr,
    output logic [DM_ADDR_W-1:0] dm_write_addr,
    output logic [DM_DATA_W-1:0] dm_write_data,
    output logic                 dm_we,
    input  logic [DM_DATA_W-1:0] dm_read_data
);
    // state       | meaning
    // ST_IDLE     | ready for a request
    // ST_WR_SETUP | store addr/data settle one cycle before dm_we
    // ST_WR_PULSE | dm_we high for WE_PULSE cycles
    // ST_WR_HOLD  | dm_we low (write committed), store ack
    // ST_RD_WAIT  | read address settling for RD_WAIT cycles
    // ST_RD_DONE  | load ack with captured data
    // ST_ERR      | out-of-range ack, no memory access

    localparam int               CNT_W   = cnt_width(WE_PULSE, RD_WAIT);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_req_we;
    logic [DM_ADDR_W-1:0]   r_rd_addr;
    logic [DM_ADDR_W-1:0]   r_wr_addr;
    logic [DM_DATA_W-1:0]   r_wr_data;
    logic [DM_DATA_W-1:0]   r_rdata;
    logic                   w_accept;
    logic                   w_oor;
    logic                   w_pg_start;
    logic                   w_pg_we;
    logic [CNT_W-1:0]       w_pg_load;
    logic                   w_pg_done;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_oor    = req_addr > DM_TOP;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_oor)       w_state_nxt = ST_ERR;
                    else if (req_we) w_state_nxt = ST_WR_SETUP;
                    else             w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
            ST_WR_PULSE: if (w_pg_done) w_state_nxt = ST_WR_HOLD;
            ST_WR_HOLD:  w_state_nxt = ST_IDLE;
            ST_RD_WAIT:  if (w_pg_done) w_state_nxt = ST_RD_DONE;
            ST_RD_DONE:  w_state_nxt = ST_IDLE;
            ST_ERR:      w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // The shared timer times the dm_we pulse for stores and the settle window for loads.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = 1'b0;
        resp_we    = 1'b0;
        resp_err   = 1'b0;
        w_pg_start = 1'b0;
        w_pg_we    = 1'b0;
        w_pg_load  = RD_LOAD;
        case (r_state)
            ST_IDLE: begin
                w_pg_start = w_accept && !w_oor && !req_we;
            end
            ST_WR_SETUP: begin
                w_pg_start = 1'b1;
                w_pg_we    = 1'b1;
                w_pg_load  = WE_LOAD;
            end
            ST_WR_HOLD: begin
                resp_valid = 1'b1;
                resp_we    = 1'b1;
            end
            ST_RD_DONE: begin
                resp_valid = 1'b1;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                resp_we    = r_req_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_req_we  <= 1'b0;
            r_rd_addr <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) r_req_we <= req_we;
            if (w_accept && !w_oor && !req_we) r_rd_addr <= req_addr;
            if ((r_state == ST_RD_WAIT) && w_pg_done) r_rdata <= dm_read_data;
        end
    end

    // Store address/data are deliberately unreset so a reset mid-pulse still
    // presents the in-flight word to the memory as dm_we falls.
    always_ff @(posedge clk) begin
        if (w_accept && !w_oor && req_we) begin
            r_wr_addr <= req_addr;
            r_wr_data <= req_wdata;
        end
    end

    dm_we_pulse_gen #(.CNT_W(CNT_W)) u_pulse (
        .clk     (clk),
        .rst_f   (rst_f),
        .i_start (w_pg_start),
        .i_we    (w_pg_we),
        .i_load  (w_pg_load),
        .o_we    (dm_we),
        .o_done  (w_pg_done)
    );

    assign resp_rdata    = r_rdata;
    assign dm_read_addr  = r_rd_addr;
    assign dm_write_addr = r_wr_addr;
    assign dm_write_data = r_wr_data;
endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu with a behavioural data memory that commits on dm_we falling.
module tb_dm_lsu;
    localparam int WE_PULSE = 2;
    localparam int RD_WAIT  = 1;
    localparam int LAT_ST   = WE_PULSE + 2;
    localparam int LAT_LD   = RD_WAIT + 1;
    localparam int LAT_ERR  = 1;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_we, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] dm_read_addr, dm_write_addr;
    logic [31:0] dm_write_data;
    logic        dm_we;
    logic [31:0] dm_read_data;

    dm_lsu #(.WE_PULSE(WE_PULSE), .RD_WAIT(RD_WAIT), .DM_TOP(16'hFFFC)) dut (
        .clk(clk), .rst_f(rst_f),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
        .dm_write_data(dm_write_data), .dm_we(dm_we), .dm_read_data(dm_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255] = '{default: 32'h0};
    int          commits = 0;
    int          we_hi = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    assign dm_read_data = mem[dm_read_addr[7:0]];

    initial forever begin
        @(negedge dm_we);
        mem[dm_write_addr[7:0]] = dm_write_data;
        commits++;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (dm_we) we_hi++;
    end

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency is counted to the posedge that consumes resp_valid.
    initial begin
        exp_t e;
        int   lat;
        logic prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                check("resp_no_overlap", !prev_resp, 32'(prev_resp), 32'd0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", 1'b0, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    lat = cyc - e.acc + 1;
                    check("resp_we", resp_we == e.we, 32'(resp_we), 32'(e.we));
                    check("resp_err", resp_err == e.err, 32'(resp_err), 32'(e.err));
                    check("resp_latency", lat == e.lat, 32'(lat), 32'(e.lat));
                    if (!e.we && !e.err)
                        check("resp_rdata", resp_rdata == e.rd, resp_rdata, e.rd);
                end
            end
            prev_resp = resp_valid;
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input logic exp_resp);
        int   n;
        exp_t e;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 1'b0, 32'(n), 32'd50);
        end else begin
            e.we  = we;
            e.err = exp_err;
            e.rd  = exp_rd;
            e.lat = exp_err ? LAT_ERR : (we ? LAT_ST : LAT_LD);
            e.acc = cyc + 1;
            if (exp_resp) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size() == 0, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    logic [15:0] t6_addr [0:3] = '{16'h0050, 16'h0051, 16'h0052, 16'h0053};
    logic [31:0] t6_data [0:3] = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, 32'h00000001};

    initial begin
        int c0, w0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
        check("rst_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'd0);
        check("rst_dm_we", dm_we == 1'b0, 32'(dm_we), 32'd0);
        check("rst_rd_addr", dm_read_addr == 16'h0, 32'(dm_read_addr), 32'd0);
        check("rst_rdata", resp_rdata == 32'h0, resp_rdata, 32'd0);
        rst_f = 1'b1;
        @(negedge clk);

        // 1: store, pulse width and commit
        w0 = we_hi; c0 = commits;
        issue(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        drain();
        check("t1_we_width", (we_hi - w0) == WE_PULSE, 32'(we_hi - w0), 32'(WE_PULSE));
        check("t1_commits", (commits - c0) == 1, 32'(commits - c0), 32'd1);
        check("t1_mem", mem[8'h10] == 32'hDEADBEEF, mem[8'h10], 32'hDEADBEEF);

        // 2: preload 0x20 through the block, then load it
        issue(1'b1, 16'h0020, 32'h12345678, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b0, 16'h0020, 32'h0, 32'h12345678, 1'b0, 1'b1);
        req_valid = 1'b0;
        check("t2_ready_low", req_ready == 1'b0, 32'(req_ready), 32'd0);
        drain();

        // 3: store then immediate load of the same word
        issue(1'b1, 16'h0030, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        check("t3_we_high", dm_we == 1'b1, 32'(dm_we), 32'd1);
        check("t3_wr_addr", dm_write_addr == 16'h0030, 32'(dm_write_addr), 32'h30);
        check("t3_wr_data", dm_write_data == 32'hA5A5A5A5, dm_write_data, 32'hA5A5A5A5);
        issue(1'b0, 16'h0030, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
        drain();

        // 4: out-of-range load and store
        w0 = we_hi; c0 = commits;
        issue(1'b0, 16'hFFFE, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 16'hFFFD, 32'h99999999, 32'h0, 1'b1, 1'b1);
        drain();
        check("t4_no_we", (we_hi - w0) == 0, 32'(we_hi - w0), 32'd0);
        check("t4_no_commit", (commits - c0) == 0, 32'(commits - c0), 32'd0);
        check("t4_mem_30", mem[8'h30] == 32'hA5A5A5A5, mem[8'h30], 32'hA5A5A5A5);

        // 5: reset in the second WR_PULSE cycle
        c0 = commits;
        issue(1'b1, 16'h0040, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_we_before_rst", dm_we == 1'b1, 32'(dm_we), 32'd1);
        rst_f = 1'b0;
        #1;
        check("t5_we_drop", dm_we == 1'b0, 32'(dm_we), 32'd0);
        check("t5_commit_once", (commits - c0) == 1, 32'(commits - c0), 32'd1);
        check("t5_mem", mem[8'h40] == 32'h0BADF00D, mem[8'h40], 32'h0BADF00D);
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
        check("t5_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'd0);
        check("t5_rdata", resp_rdata == 32'h0, resp_rdata, 32'd0);
        check("t5_rd_addr", dm_read_addr == 16'h0, 32'(dm_read_addr), 32'd0);
        check("t5_commit_total", (commits - c0) == 1, 32'(commits - c0), 32'd1);

        // 6: req_valid held high across alternating store/load pairs
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, t6_addr[i], t6_data[i], 32'h0, 1'b0, 1'b1);
            issue(1'b0, t6_addr[i], 32'h0, t6_data[i], 1'b0, 1'b1);
        end
        drain();
        check("t6_mem_52", mem[8'h52] == 32'hCAFEF00D, mem[8'h52], 32'hCAFEF00D);

        repeat (5) @(negedge clk);
        check("final_sb_empty", sb.size() == 0, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
